// File: rtl/adder_sum_accumulator_if.sv
// Handshake bundle between a 4-bit adder source, the batch accumulator and its consumer.
interface adder_sum_accumulator_if #(
  parameter int ACC_W = 8
);
  logic [3:0]       sum;
  logic             cout;
  logic             in_valid;
  logic             in_ready;
  logic             clear;
  logic [ACC_W-1:0] acc;
  logic             overflow;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output sum, cout, in_valid, clear, out_ready,
    input  in_ready, acc, overflow, out_valid
  );

  modport slave (
    input  sum, cout, in_valid, clear, out_ready,
    output in_ready, acc, overflow, out_valid
  );
endinterface

// File: rtl/adder_sum_accumulator.sv
// Sums COUNT carry-extended adder results per batch and presents the total
// with a sticky overflow flag until the consumer takes it.
module adder_sum_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  adder_sum_accumulator_if.slave bus
);

  typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic [3:0]       r_cnt;
  logic             r_ovf;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_last;
  logic             w_handoff;
  logic [ACC_W-1:0] w_operand;
  logic [ACC_W:0]   w_sum_wide;

  // Top bit of the result is the carry out of the accumulator width.
  function automatic logic [ACC_W:0] f_add_wide(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign w_operand  = ACC_W'({bus.cout, bus.sum});
  assign w_sum_wide = f_add_wide(r_acc, w_operand);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_last     = (r_cnt == 4'(COUNT - 1));
  assign w_handoff  = (r_state == PRESENT) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= COLLECT;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.clear) begin
      w_state_next = COLLECT;
    end else begin
      case (r_state)
        COLLECT: if (w_accept && w_last) w_state_next = PRESENT;
        PRESENT: if (bus.out_ready)      w_state_next = COLLECT;
        default:                         w_state_next = COLLECT;
      endcase
    end
  end

  always_comb begin
    w_in_ready  = (r_state == COLLECT);
    w_out_valid = (r_state == PRESENT);
  end

  // Accumulate stage: clear beats handoff, handoff beats accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (bus.clear || w_handoff) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum_wide[ACC_W-1:0];
      r_cnt <= r_cnt + 4'd1;
      r_ovf <= r_ovf | w_sum_wide[ACC_W];
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.acc       = r_acc;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Randomized and directed bench for adder_sum_accumulator; two instances
// (ACC_W=8 and ACC_W=6) share stimulus and are compared against a batch model.
module tb_adder_sum_accumulator;
  localparam int COUNT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_sum_accumulator_if #(.ACC_W(8)) bus_a ();
  adder_sum_accumulator_if #(.ACC_W(6)) bus_b ();

  adder_sum_accumulator #(.COUNT(COUNT), .ACC_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  adder_sum_accumulator #(.COUNT(COUNT), .ACC_W(6)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: true batch total, operands taken so far, and whether a total is on offer.
  int m_total   = 0;
  int m_n       = 0;
  bit m_present = 1'b0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk_val({tag, "_in_ready"},  32'(bus_a.in_ready),  32'(!m_present));
    chk_val({tag, "_out_valid"}, 32'(bus_a.out_valid), 32'(m_present));
    chk_val({tag, "_acc8"},      32'(bus_a.acc),       32'(m_total % 256));
    chk_val({tag, "_ovf8"},      32'(bus_a.overflow),  32'(m_total >= 256));
    chk_val({tag, "_acc6"},      32'(bus_b.acc),       32'(m_total % 64));
    chk_val({tag, "_ovf6"},      32'(bus_b.overflow),  32'(m_total >= 64));
    chk_val({tag, "_rdy6"},      32'(bus_b.in_ready),  32'(!m_present));
  endtask

  task automatic drive(input bit v, input logic [4:0] op, input bit clr, input bit ordy);
    bus_a.in_valid = v;   bus_b.in_valid = v;
    bus_a.cout = op[4];   bus_b.cout = op[4];
    bus_a.sum = op[3:0];  bus_b.sum = op[3:0];
    bus_a.clear = clr;    bus_b.clear = clr;
    bus_a.out_ready = ordy; bus_b.out_ready = ordy;
  endtask

  task automatic model_reset();
    m_total = 0; m_n = 0; m_present = 1'b0;
  endtask

  // One clock with the given inputs; model advances on the edge, outputs checked 1 ns later.
  task automatic step(input string tag, input bit v, input logic [4:0] op,
                      input bit clr, input bit ordy);
    drive(v, op, clr, ordy);
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else if (m_present) begin
      if (ordy) model_reset();
    end else if (v) begin
      m_total += int'(op);
      m_n++;
      if (m_n == COUNT) m_present = 1'b1;
    end
    #1;
    check_all(tag);
  endtask

  // Asserts reset between edges and checks outputs before any clock arrives.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all({tag, "_imm"});
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    check_all("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Normal batch of 2s, then hand off.
    for (int i = 0; i < COUNT; i++) step("norm", 1'b1, 5'd2, 1'b0, 1'b0);
    chk_val("norm_acc_eq8", 32'(bus_a.acc), 32'd8);
    step("norm_hand", 1'b0, 5'd0, 1'b0, 1'b1);

    // Maximum operands; narrow instance wraps and flags overflow.
    for (int i = 0; i < COUNT; i++) step("max", 1'b1, 5'd31, 1'b0, 1'b0);
    chk_val("max_acc_eq124", 32'(bus_a.acc), 32'd124);
    chk_val("ovf6_acc_eq60", 32'(bus_b.acc), 32'd60);
    chk_val("ovf6_flag",     32'(bus_b.overflow), 32'd1);

    // Backpressure while offering operand 7.
    for (int i = 0; i < 3; i++) step("bp", 1'b1, 5'd7, 1'b0, 1'b0);
    chk_val("bp_acc_held", 32'(bus_a.acc), 32'd124);
    step("bp_hand", 1'b1, 5'd7, 1'b0, 1'b1);
    chk_val("hand_acc0",  32'(bus_a.acc), 32'd0);
    chk_val("hand_ovf6",  32'(bus_b.overflow), 32'd0);

    // Reset mid-batch, then first edge after release must accept.
    step("rst_pre", 1'b1, 5'd5, 1'b0, 1'b0);
    step("rst_pre", 1'b1, 5'd5, 1'b0, 1'b0);
    chk_val("rst_pre_acc10", 32'(bus_a.acc), 32'd10);
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    async_reset("rst_mid");
    step("rst_first", 1'b1, 5'd9, 1'b0, 1'b0);

    // Clear with a simultaneous operand.
    step("clr_pre", 1'b1, 5'd5, 1'b0, 1'b0);
    step("clr_drop", 1'b1, 5'd5, 1'b1, 1'b0);
    chk_val("clr_acc0", 32'(bus_a.acc), 32'd0);
    for (int i = 0; i < COUNT; i++) step("clr_cnt", 1'b1, 5'd1, 1'b0, 1'b0);

    // Clear in PRESENT wins over out_ready; then reset while PRESENT.
    step("clr_pres", 1'b1, 5'd3, 1'b1, 1'b1);
    for (int i = 0; i < COUNT; i++) step("pres_fill", 1'b1, 5'd20, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    async_reset("rst_pres");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit v, clr, ordy;
      logic [4:0] op;
      v    = ($urandom_range(0, 9) < 7);
      op   = 5'($urandom_range(0, 31));
      clr  = ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 1) == 1);
      step("rand", v, op, clr, ordy);
      if ($urandom_range(0, 99) == 0) begin
        drive(1'b0, 5'd0, 1'b0, 1'b0);
        async_reset("rand_rst");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_sum_accumulator.md
ADDER_SUM_ACCUMULATOR -- requirements
Module: adder_sum_accumulator

Interface
REQ-001 The block SHALL have parameter COUNT, default 4, giving the number of adder results summed per batch (legal 2..15).
REQ-002 The block SHALL have parameter ACC_W, default 8, giving the accumulator width in bits (legal 5..16).
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 sum  input  4  sum output of the upstream 4-bit adder.
REQ-007 cout  input  1  carry output of the upstream 4-bit adder.
REQ-008 in_valid  input  1  sum/cout hold a result to be consumed this cycle.
REQ-009 in_ready  output  1  block accepts a result this cycle.
REQ-010 clear  input  1  synchronous batch abort.
REQ-011 acc  output  ACC_W  running and final batch total.
REQ-012 overflow  output  1  sticky flag; batch total exceeded ACC_W bits.
REQ-013 out_valid  output  1  acc holds a completed batch total.
REQ-014 out_ready  input  1  downstream takes the batch total.

Function
REQ-015 Each accepted operand SHALL be the 5-bit unsigned value {cout,sum} (range 0..31), zero-extended to ACC_W bits.
REQ-016 The FSM SHALL have two states: COLLECT (in_ready=1, out_valid=0) and PRESENT (in_ready=0, out_valid=1).
REQ-017 An accept SHALL occur on a rising edge with in_valid=1 and in_ready=1, and only then.
REQ-018 On each accept, acc SHALL become (acc + operand) mod 2^ACC_W, and a 4-bit internal count SHALL increment.
REQ-019 overflow SHALL be set on any accept whose true sum is at least 2^ACC_W, and SHALL stay set until the batch ends.
REQ-020 The accept that brings count to COUNT SHALL move the FSM to PRESENT, with out_valid=1 from the next cycle and acc holding the total including that operand.
REQ-021 In PRESENT, acc, overflow and out_valid SHALL hold stable while out_ready=0, and in_valid SHALL be ignored.
REQ-022 In PRESENT with out_ready=1 at a rising edge, the FSM SHALL return to COLLECT, and acc, count and overflow SHALL become 0 on that edge.
REQ-023 clear=1 at a rising edge SHALL force COLLECT with acc, count and overflow 0, in either state.
REQ-024 clear SHALL take priority over a simultaneous accept or out_ready; that operand SHALL be discarded.
REQ-025 In COLLECT, acc SHALL be visible as a running partial sum; its value is valid only when out_valid=1.
REQ-026 Latency SHALL be one cycle: the operand accepted at edge N is reflected in acc after edge N.
REQ-027 in_ready SHALL be a registered function of state only, with no combinational path from in_valid or out_ready.

Reset
REQ-028 While rst_n=0, the block SHALL be in COLLECT with acc=0, count=0, overflow=0, out_valid=0 and in_ready=1, independent of clk.
REQ-029 Reset assertion mid-batch or in PRESENT SHALL discard all partial state immediately.
REQ-030 After rst_n deasserts, the first rising edge SHALL be able to accept an operand.

Verification
REQ-031 Normal batch (defaults): sum=4'b0010, cout=0, in_valid=1 for 4 consecutive cycles -> acc=8, out_valid=1 after the 4th edge, overflow=0, in_ready=0.
REQ-032 Maximum operands (defaults): {cout,sum}=5'b11111 for 4 accepts -> acc=124, overflow=0; then out_ready=1 for one cycle -> acc=0, in_ready=1.
REQ-033 Overflow (ACC_W=6): four accepts of 31 -> acc=60, overflow=1; the flag holds through PRESENT and clears on handoff.
REQ-034 Backpressure: hold out_ready=0 for 3 cycles in PRESENT while driving in_valid=1 with operand 7 -> acc, out_valid and overflow remain unchanged and no operand is absorbed.
REQ-035 Reset/clear mid-batch: after 2 accepts of 5 (acc=10), pulse rst_n low asynchronously -> all outputs reach reset values immediately; repeat using clear=1 together with in_valid=1 -> acc=0, count=0, operand dropped.
